// File: rtl/band_level_tracker_if.sv
// Sample-stream handshake from the audio front end into band_level_tracker.
// The front end drives the master side; the tracker exerts back-pressure via sample_ready.
interface band_level_tracker_if #(
  parameter int SAMPLE_W = 16,
  parameter int BAND_W   = 3
);
  logic                sample_valid;
  logic                sample_ready;
  logic [SAMPLE_W-1:0] sample_data;
  logic [BAND_W-1:0]   sample_band;

  modport master (
    output sample_valid,
    output sample_data,
    output sample_band,
    input  sample_ready
  );

  modport slave (
    input  sample_valid,
    input  sample_data,
    input  sample_band,
    output sample_ready
  );
endinterface

// File: rtl/band_level_tracker.sv
// Per-band peak tracker: accumulates |sample| peaks per band over a video frame, then on
// each vsync falling edge converts peaks to bar heights with peak-hold decay, one band per cycle.
module band_level_tracker #(
  parameter int NUM_BANDS  = 8,
  parameter int SAMPLE_W   = 16,
  parameter int BAND_W     = $clog2(NUM_BANDS),
  parameter int HEIGHT_W   = 9,
  parameter int MAX_HEIGHT = 400,
  parameter int SHIFT      = 6,
  parameter int DECAY      = 4
) (
  input  logic                 Clk,
  input  logic                 Reset_n,
  band_level_tracker_if.slave  smp,
  input  logic                 frame_vs,
  input  logic [BAND_W-1:0]    rd_band,
  output logic [HEIGHT_W-1:0]  rd_height,
  output logic                 frame_done
);

  localparam int MAG_W = SAMPLE_W - 1;
  localparam int IDX_W = $clog2(NUM_BANDS);

  localparam logic [BAND_W:0]     NUM_BANDS_B = (BAND_W + 1)'(NUM_BANDS);
  localparam logic [MAG_W-1:0]    MAX_H_MAG   = MAG_W'(MAX_HEIGHT);
  localparam logic [HEIGHT_W-1:0] MAX_H       = HEIGHT_W'(MAX_HEIGHT);
  localparam logic [HEIGHT_W-1:0] DECAY_H     = HEIGHT_W'(DECAY);
  localparam logic [IDX_W-1:0]    LAST_IDX    = IDX_W'(NUM_BANDS - 1);

  typedef enum logic [0:0] {
    ACCUM  = 1'b0,
    UPDATE = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic                vs_q;
  logic                tick;
  logic                upd_last;

  logic [MAG_W-1:0]    peak [NUM_BANDS];
  logic [HEIGHT_W-1:0] disp [NUM_BANDS];

  // Magnitude with the most-negative code saturated to the largest positive value.
  logic [SAMPLE_W-1:0] neg_data;
  logic [MAG_W-1:0]    mag;

  always_comb begin
    neg_data = '0 - smp.sample_data;
    if (!smp.sample_data[SAMPLE_W-1]) begin
      mag = smp.sample_data[MAG_W-1:0];
    end else if (neg_data[SAMPLE_W-1]) begin
      mag = '1;
    end else begin
      mag = neg_data[MAG_W-1:0];
    end
  end

  logic             in_range;
  logic             accept;
  logic [IDX_W-1:0] smp_idx;

  assign smp.sample_ready = (state_q == ACCUM);
  assign in_range         = ({1'b0, smp.sample_band} < NUM_BANDS_B);
  assign smp_idx          = smp.sample_band[IDX_W-1:0];
  assign accept           = smp.sample_valid && smp.sample_ready && in_range;
  assign tick             = (state_q == ACCUM) && vs_q && !frame_vs;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q    <= ACCUM;
      idx_q      <= '0;
      vs_q       <= 1'b1;
      frame_done <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      vs_q       <= frame_vs;
      frame_done <= upd_last;
    end
  end

  // NOTE: every output of this block gets a default first, so no path leaves one unassigned (no latch).
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    upd_last = 1'b0;
    case (state_q)
      ACCUM: begin
        if (tick) begin
          state_d = UPDATE;
          idx_d   = '0;
        end
      end
      UPDATE: begin
        idx_d = idx_q + IDX_W'(1);
        if (idx_q == LAST_IDX) begin
          upd_last = 1'b1;
          state_d  = ACCUM;
          idx_d    = '0;
        end
      end
      default: begin
        state_d = ACCUM;
        idx_d   = '0;
      end
    endcase
  end

  // Height for the band being refreshed: clamp before narrowing, decay floors at zero.
  logic [MAG_W-1:0]    shifted;
  logic [HEIGHT_W-1:0] h_new, h_dec, h_next;

  always_comb begin
    shifted = peak[idx_q] >> SHIFT;
    h_new   = (shifted > MAX_H_MAG) ? MAX_H : shifted[HEIGHT_W-1:0];
    h_dec   = (disp[idx_q] > DECAY_H) ? (disp[idx_q] - DECAY_H) : '0;
    h_next  = (h_new > h_dec) ? h_new : h_dec;
  end

  // NOTE: these small arrays are flop banks, not RAM, so they are reset; a mid-update reset must clear them.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int i = 0; i < NUM_BANDS; i++) begin
        peak[i] <= '0;
        disp[i] <= '0;
      end
    end else if (state_q == UPDATE) begin
      peak[idx_q] <= '0;
      disp[idx_q] <= h_next;
    end else if (accept && (mag > peak[smp_idx])) begin
      peak[smp_idx] <= mag;
    end
  end

  // Registered read port; out-of-range bands read as zero.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      rd_height <= '0;
    end else if ({1'b0, rd_band} < NUM_BANDS_B) begin
      rd_height <= disp[rd_band[IDX_W-1:0]];
    end else begin
      rd_height <= '0;
    end
  end

endmodule
